// File: rtl/spi_target_regs.sv
// SPI mode-0 target giving an external host byte-wide read/write access to a small register file.
// All SPI pins are oversampled in the clk_i domain; nothing here is clocked by SCK.
module spi_target_regs #(
    parameter int NumRegs    = 16,
    parameter int SyncStages = 2,
    localparam int AW        = $clog2(NumRegs)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 spi_sck_i,
    input  logic                 spi_csb_i,
    input  logic                 spi_sd_i,
    output logic                 spi_sd_o,
    output logic                 spi_sd_en_o,
    output logic [NumRegs*8-1:0] regs_o,
    output logic                 wr_valid_o,
    output logic [AW-1:0]        wr_addr_o,
    output logic [7:0]           wr_data_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_e;

    logic [SyncStages-1:0] sck_sync_q, csb_sync_q, sd_sync_q;
    logic                  sck_dly_q, csb_dly_q;
    logic                  sck_rise_q, sck_fall_q, csb_rise_q, csb_fall_q;
    logic                  sd_bit_q, busy_q;

    logic                  sck_s, csb_s;
    assign sck_s = sck_sync_q[SyncStages-1];
    assign csb_s = csb_sync_q[SyncStages-1];

    // CSB chain resets to "selected" so a CSB held low across reset release never looks like a fresh fall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q <= '0;
            csb_sync_q <= '0;
            sd_sync_q  <= '0;
            sck_dly_q  <= 1'b0;
            csb_dly_q  <= 1'b0;
            sck_rise_q <= 1'b0;
            sck_fall_q <= 1'b0;
            csb_rise_q <= 1'b0;
            csb_fall_q <= 1'b0;
            sd_bit_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SyncStages-2:0], spi_sck_i};
            csb_sync_q <= {csb_sync_q[SyncStages-2:0], spi_csb_i};
            sd_sync_q  <= {sd_sync_q[SyncStages-2:0], spi_sd_i};
            sck_dly_q  <= sck_s;
            csb_dly_q  <= csb_s;
            sck_rise_q <= sck_s & ~sck_dly_q;
            sck_fall_q <= ~sck_s & sck_dly_q;
            csb_rise_q <= csb_s & ~csb_dly_q;
            csb_fall_q <= ~csb_s & csb_dly_q;
            sd_bit_q   <= sd_sync_q[SyncStages-1];
            busy_q     <= ~csb_s;
        end
    end

    state_e       state_q;
    logic [2:0]   cnt_q;
    logic [6:0]   rx_sh_q;
    logic [7:0]   tx_sh_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]   regs_q [NumRegs];
    logic         sd_q, sd_en_q, wr_valid_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]   wr_data_q;

    logic [7:0]   rx_byte_d;
    logic [AW-1:0] ptr_d;
    logic         byte_done;
    assign rx_byte_d = {rx_sh_q, sd_bit_q};
    assign ptr_d     = ptr_q + AW'(1);
    assign byte_done = sck_rise_q && (cnt_q == 3'd7);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            ptr_q      <= '0;
            sd_q       <= 1'b0;
            sd_en_q    <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else begin
            wr_valid_q <= 1'b0;
            // A CSB rise wins over a coincident 8th SCK rise, so a racing byte is dropped.
            if (csb_rise_q) begin
                state_q <= IDLE;
                sd_q    <= 1'b0;
                sd_en_q <= 1'b0;
            end else if (csb_fall_q) begin
                state_q <= CMD;
                cnt_q   <= '0;
                rx_sh_q <= '0;
                sd_q    <= 1'b0;
                sd_en_q <= 1'b0;
            end else begin
                if (sck_rise_q && state_q != IDLE) begin
                    cnt_q   <= cnt_q + 3'd1;
                    rx_sh_q <= rx_byte_d[6:0];
                end
                case (state_q)
                    CMD: begin
                        if (byte_done) begin
                            ptr_q <= rx_byte_d[AW-1:0];
                            if (rx_byte_d[7]) begin
                                state_q <= READ;
                                sd_en_q <= 1'b1;
                                tx_sh_q <= regs_q[rx_byte_d[AW-1:0]];
                            end else begin
                                state_q <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (byte_done) begin
                            regs_q[ptr_q] <= rx_byte_d;
                            wr_valid_q    <= 1'b1;
                            wr_addr_q     <= ptr_q;
                            wr_data_q     <= rx_byte_d;
                            ptr_q         <= ptr_d;
                        end
                    end
                    READ: begin
                        if (sck_fall_q) begin
                            sd_q    <= tx_sh_q[7];
                            tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                        end
                        if (byte_done) begin
                            ptr_q   <= ptr_d;
                            tx_sh_q <= regs_q[ptr_d];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NumRegs; gi++) begin : g_regs
        assign regs_o[gi*8 +: 8] = regs_q[gi];
    end

    assign spi_sd_o    = sd_q;
    assign spi_sd_en_o = sd_en_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed and randomized bench for spi_target_regs: SCK at f_clk/10, host model bit-banged from tasks.
module tb_spi_target_regs;
    localparam int NR   = 16;
    localparam int SS   = 2;
    localparam int HALF = SS + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sck, csb, sdi;
    logic          sd_o, sd_en;
    logic [NR*8-1:0] regs;
    logic          wr_valid;
    logic [3:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          busy;

    spi_target_regs #(.NumRegs(NR), .SyncStages(SS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .spi_sck_i(sck), .spi_csb_i(csb), .spi_sd_i(sdi),
        .spi_sd_o(sd_o), .spi_sd_en_o(sd_en),
        .regs_o(regs), .wr_valid_o(wr_valid), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] wr_q[$];
    logic [7:0]  ref_regs[NR];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write strobe seen is queued; a 2-cycle pulse shows up as an extra entry.
    always @(negedge clk) if (wr_valid) wr_q.push_back({wr_addr, wr_data});

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx,
                             output logic en_and, output logic en_or);
        rx = '0; en_and = 1'b1; en_or = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            sdi = tx[7-i];
            wait_clk(HALF);
            rx[7-i] = sd_o;
            en_and &= sd_en;
            en_or  |= sd_en;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic txn(input logic [7:0] b0, b1, b2, b3, input int len,
                       output logic [7:0] r1, r2, r3, output logic en_cmd, output logic en_data);
        logic [7:0] tx[4];
        logic [7:0] rx[4];
        logic a, o;
        tx = '{b0, b1, b2, b3};
        rx = '{8'h0, 8'h0, 8'h0, 8'h0};
        en_cmd = 1'b0; en_data = 1'b1;
        csb = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k <= len; k++) begin
            xfer_bits(tx[k], 8, rx[k], a, o);
            if (k == 0) en_cmd = o;
            else en_data &= a;
        end
        wait_clk(HALF);
        csb = 1'b1;
        wait_clk(HALF);
        r1 = rx[1]; r2 = rx[2]; r3 = rx[3];
    endtask

    task automatic check_strobe(input string tag, input logic [3:0] a, input logic [7:0] d);
        logic [11:0] e;
        e = (wr_q.size() > 0) ? wr_q.pop_front() : 12'hxxx;
        check_eq(tag, {116'd0, e}, {116'd0, a, d});
    endtask

    function automatic logic [127:0] ref_vec();
        logic [127:0] v;
        for (int k = 0; k < NR; k++) v[k*8 +: 8] = ref_regs[k];
        return v;
    endfunction

    initial begin
        logic [7:0] r1, r2, r3, rx;
        logic ec, ed, ea, eo;
        for (int k = 0; k < NR; k++) ref_regs[k] = 8'h00;

        // Reset with CSB low and SCK toggling
        rst_n = 1'b0; csb = 1'b0; sck = 1'b0; sdi = 1'b1;
        for (int i = 0; i < 6; i++) begin wait_clk(2); sck = ~sck; end
        check_eq("rst regs", regs, '0);
        check_eq("rst sd_o/en/valid/busy", {124'd0, sd_o, sd_en, wr_valid, busy}, '0);
        check_eq("rst wr_addr/data", {116'd0, wr_addr, wr_data}, '0);
        sck = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(HALF);
        check_eq("busy after release", {127'd0, busy}, 128'd1);
        wr_q.delete();
        xfer_bits(8'h80, 8, rx, ea, eo);
        xfer_bits(8'hEE, 8, rx, ea, eo);
        check_eq("no en without fresh fall", {127'd0, eo}, '0);
        check_eq("no strobe without fresh fall", wr_q.size(), 0);
        check_eq("regs still zero", regs, '0);
        csb = 1'b1;
        wait_clk(2 * HALF);
        check_eq("busy idle", {127'd0, busy}, '0);

        // Burst write
        wr_q.delete();
        txn(8'h03, 8'hA5, 8'h5A, 8'h00, 2, r1, r2, r3, ec, ed);
        ref_regs[3] = 8'hA5; ref_regs[4] = 8'h5A;
        check_eq("burst strobe count", wr_q.size(), 2);
        check_strobe("burst strobe0", 4'd3, 8'hA5);
        check_strobe("burst strobe1", 4'd4, 8'h5A);
        check_eq("reg3", regs[31:24], 8'hA5);
        check_eq("reg4", regs[39:32], 8'h5A);

        // Read-back
        txn(8'h83, 8'h00, 8'h00, 8'h00, 2, r1, r2, r3, ec, ed);
        check_eq("rd byte0", r1, 8'hA5);
        check_eq("rd byte1", r2, 8'h5A);
        check_eq("rd en during cmd", {127'd0, ec}, '0);
        check_eq("rd en during data", {127'd0, ed}, 128'd1);
        check_eq("en/sdo after csb rise", {126'd0, sd_en, sd_o}, '0);

        // Wrap-around and aliasing
        wr_q.delete();
        txn(8'h0F, 8'h11, 8'h22, 8'h00, 2, r1, r2, r3, ec, ed);
        ref_regs[15] = 8'h11; ref_regs[0] = 8'h22;
        check_eq("wrap reg15", regs[127:120], 8'h11);
        check_eq("wrap reg0", regs[7:0], 8'h22);
        check_strobe("wrap strobe0", 4'd15, 8'h11);
        check_strobe("wrap strobe1", 4'd0, 8'h22);
        txn(8'h8F, 8'h00, 8'h00, 8'h00, 2, r1, r2, r3, ec, ed);
        check_eq("wrap rd0", r1, 8'h11);
        check_eq("wrap rd1", r2, 8'h22);
        wr_q.delete();
        txn(8'h1F, 8'h33, 8'h00, 8'h00, 1, r1, r2, r3, ec, ed);
        ref_regs[15] = 8'h33;
        check_strobe("alias strobe", 4'd15, 8'h33);
        check_eq("alias reg15", regs[127:120], 8'h33);

        // Abort mid-byte
        wr_q.delete();
        csb = 1'b0;
        wait_clk(HALF);
        xfer_bits(8'h02, 8, rx, ea, eo);
        xfer_bits(8'hFF, 5, rx, ea, eo);
        wait_clk(HALF);
        csb = 1'b1;
        wait_clk(2 * HALF);
        check_eq("abort no strobe", wr_q.size(), 0);
        check_eq("abort reg2", regs[23:16], 8'h00);
        txn(8'h02, 8'h77, 8'h00, 8'h00, 1, r1, r2, r3, ec, ed);
        ref_regs[2] = 8'h77;
        check_strobe("after abort strobe", 4'd2, 8'h77);
        check_eq("after abort reg2", regs[23:16], 8'h77);

        // Random back-to-back traffic against the reference model
        for (int t = 0; t < 64; t++) begin
            logic [6:0] addr;
            logic [7:0] d[3];
            logic [7:0] got[3];
            int len;
            bit is_rd;
            is_rd = 1'($urandom_range(0, 1));
            addr  = 7'($urandom_range(0, 127));
            len   = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) d[k] = 8'($urandom_range(0, 255));
            wr_q.delete();
            txn({is_rd, addr}, d[0], d[1], d[2], len, got[0], got[1], got[2], ec, ed);
            for (int k = 0; k < len; k++) begin
                logic [3:0] a;
                a = 4'(addr) + 4'(k);
                if (is_rd) begin
                    check_eq($sformatf("rnd%0d rd a%0d", t, a), got[k], ref_regs[a]);
                end else begin
                    check_strobe($sformatf("rnd%0d wr a%0d", t, a), a, d[k]);
                    ref_regs[a] = d[k];
                end
            end
            if (is_rd) check_eq($sformatf("rnd%0d en", t), {127'd0, ed}, 128'd1);
            else check_eq($sformatf("rnd%0d extra strobes", t), wr_q.size(), 0);
        end
        check_eq("final regs", regs, ref_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
